display_scan_controller: RTL and testbench

//  Time-multiplexes N_DIGITS BCD digits onto one shared bcdtosevensegment decoder and a common-anode digit bank.

---
 rtl/display_scan_controller.sv | 144 ++++++++++++++
 tb/tb_display_scan_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Multiplexed BCD display scanner: one digit per slot, with a ghosting guard, leading-zero
// blanking, blink, decimal point and per-frame input latching. All outputs are registered.
module display_scan_controller #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYC    = 16,
  parameter int unsigned BLINK_FRAMES = 50
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   blink_mask_i,
  input  logic [N_DIGITS-1:0]   dp_mask_i,
  input  logic                  blank_lz_i,
  output logic [3:0]            bcd_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  dp_n_o,
  output logic                  slot_strobe_o
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(N_DIGITS);
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] PrescLast = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GuardEnd  = PW'(GUARD_CYC);
  localparam logic [IW-1:0] IdxLast   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {StGuard, StShow} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_on_q, blink_on_d;
  logic [4*N_DIGITS-1:0] dig_lat_q, dig_lat_d;
  logic [N_DIGITS-1:0]   blink_lat_q, blink_lat_d;
  logic [N_DIGITS-1:0]   dp_lat_q, dp_lat_d;
  logic                  lz_lat_q, lz_lat_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  dp_n_q, dp_n_d;
  logic                  strobe_q, strobe_d;

  logic                  slot_end, frame_end;
  logic [N_DIGITS-1:0]   zero_above, blank;
  logic [3:0]            cur_digit;

  always_comb begin
    presc_d     = presc_q;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    dig_lat_d   = dig_lat_q;
    blink_lat_d = blink_lat_q;
    dp_lat_d    = dp_lat_q;
    lz_lat_d    = lz_lat_q;

    slot_end  = (presc_q == PrescLast);
    frame_end = slot_end && (idx_q == IdxLast);

    if (enable_i) begin
      presc_d = slot_end ? '0 : presc_q + 1'b1;
      if (slot_end) idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      if (frame_end) begin
        dig_lat_d   = digits_i;
        blink_lat_d = blink_mask_i;
        dp_lat_d    = dp_mask_i;
        lz_lat_d    = blank_lz_i;
        if (blink_cnt_q == BlinkLast) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end

    state_d = (presc_d < GuardEnd) ? StGuard : StShow;

    // zero_above[i]: digit i and every more significant digit are zero
    zero_above[N_DIGITS-1] = (dig_lat_q[4*N_DIGITS-1 -: 4] == 4'd0);
    for (int i = N_DIGITS - 2; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] && (dig_lat_q[4*i +: 4] == 4'd0);
    end
    blank = (blink_lat_q & {N_DIGITS{~blink_on_q}})
          | ({N_DIGITS{lz_lat_q}} & {zero_above[N_DIGITS-1:1], 1'b0});

    cur_digit = dig_lat_q[4*int'(idx_q) +: 4];

    // Nibble is driven during the guard too so the decoder settles before the anode turns on
    bcd_d    = cur_digit;
    an_d     = '1;
    dp_n_d   = 1'b1;
    strobe_d = 1'b0;
    if (enable_i) begin
      strobe_d = (presc_q == '0);
      if (state_q == StShow && !blank[idx_q]) begin
        an_d[idx_q] = 1'b0;
        dp_n_d      = ~dp_lat_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StGuard;
      presc_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      dig_lat_q   <= digits_i;
      blink_lat_q <= blink_mask_i;
      dp_lat_q    <= dp_mask_i;
      lz_lat_q    <= blank_lz_i;
      bcd_q       <= '0;
      an_q        <= '1;
      dp_n_q      <= 1'b1;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      dig_lat_q   <= dig_lat_d;
      blink_lat_q <= blink_lat_d;
      dp_lat_q    <= dp_lat_d;
      lz_lat_q    <= lz_lat_d;
      bcd_q       <= bcd_d;
      an_q        <= an_d;
      dp_n_q      <= dp_n_d;
      strobe_q    <= strobe_d;
    end
  end

  assign bcd_o         = bcd_q;
  assign an_o          = an_q;
  assign dp_n_o        = dp_n_q;
  assign slot_strobe_o = strobe_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a small refresh divider so whole frames
// fit in a few hundred cycles. Cycle k = output state after the k-th edge following reset.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  blink_mask = 4'b0000;
  logic [3:0]  dp_mask = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        dp_n;
  logic        strobe;

  int cur;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] bcd;
    logic       dp_n;
    logic       strobe;
  } vec_t;

  vec_t scan_tbl[12];

  display_scan_controller #(
    .N_DIGITS    (4),
    .REFRESH_DIV (8),
    .GUARD_CYC   (2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .digits_i     (digits),
    .blink_mask_i (blink_mask),
    .dp_mask_i    (dp_mask),
    .blank_lz_i   (blank_lz),
    .bcd_o        (bcd),
    .an_o         (an),
    .dp_n_o       (dp_n),
    .slot_strobe_o(strobe)
  );

  always #5 clk = ~clk;

  task automatic run_to(input int k);
    while (cur < k) begin
      @(posedge clk);
      cur++;
      @(negedge clk);
    end
  endtask

  task automatic check(input string name, input logic [3:0] e_an, input logic [3:0] e_bcd,
                       input logic e_dp, input logic e_stb);
    n_checks++;
    if (an === e_an && bcd === e_bcd && dp_n === e_dp && strobe === e_stb) begin
      n_pass++;
    end else begin
      $display("FAIL %s cyc=%0d: got an=%b bcd=%h dp_n=%b strobe=%b, want an=%b bcd=%h dp_n=%b strobe=%b",
               name, cur, an, bcd, dp_n, strobe, e_an, e_bcd, e_dp, e_stb);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  // Reset is held for one edge; inputs set beforehand are latched as frame 0
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cur = -1;
  endtask

  initial begin
    int bad;
    scan_tbl[0]  = '{0,  4'b1111, 4'h4, 1'b1, 1'b1};
    scan_tbl[1]  = '{1,  4'b1111, 4'h4, 1'b1, 1'b0};
    scan_tbl[2]  = '{2,  4'b1110, 4'h4, 1'b1, 1'b0};
    scan_tbl[3]  = '{7,  4'b1110, 4'h4, 1'b1, 1'b0};
    scan_tbl[4]  = '{8,  4'b1111, 4'h3, 1'b1, 1'b1};
    scan_tbl[5]  = '{10, 4'b1101, 4'h3, 1'b1, 1'b0};
    scan_tbl[6]  = '{16, 4'b1111, 4'h2, 1'b1, 1'b1};
    scan_tbl[7]  = '{18, 4'b1011, 4'h2, 1'b1, 1'b0};
    scan_tbl[8]  = '{26, 4'b0111, 4'h1, 1'b1, 1'b0};
    scan_tbl[9]  = '{31, 4'b0111, 4'h1, 1'b1, 1'b0};
    scan_tbl[10] = '{32, 4'b1111, 4'h4, 1'b1, 1'b1};
    scan_tbl[11] = '{34, 4'b1110, 4'h4, 1'b1, 1'b0};

    @(negedge clk);
    // Basic scan
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset", 4'b1111, 4'h0, 1'b1, 1'b0);
    rst = 1'b0;
    cur = -1;
    for (int i = 0; i < 12; i++) begin
      run_to(scan_tbl[i].cyc);
      check("scan", scan_tbl[i].an, scan_tbl[i].bcd, scan_tbl[i].dp_n, scan_tbl[i].strobe);
    end

    // Leading-zero blanking
    digits = 16'h0045;
    blank_lz = 1'b1;
    do_reset();
    run_to(2);  check("lz_d0", 4'b1110, 4'h5, 1'b1, 1'b0);
    run_to(10); check("lz_d1", 4'b1101, 4'h4, 1'b1, 1'b0);
    run_to(18); check("lz_d2", 4'b1111, 4'h0, 1'b1, 1'b0);
    run_to(26); check("lz_d3", 4'b1111, 4'h0, 1'b1, 1'b0);
    bad = 0;
    for (int k = 27; k < 59; k++) begin
      run_to(k);
      if (an[3:2] !== 2'b11) bad++;
    end
    check_int("lz_upper_never_on", bad, 0);
    digits = 16'h0000;
    do_reset();
    run_to(2);  check("lz0_d0", 4'b1110, 4'h0, 1'b1, 1'b0);
    run_to(10); check("lz0_d1", 4'b1111, 4'h0, 1'b1, 1'b0);
    run_to(26); check("lz0_d3", 4'b1111, 4'h0, 1'b1, 1'b0);

    // Blink: frames 0-1 on, 2-3 off, 4-5 on, 6-7 off
    digits = 16'h1234;
    blank_lz = 1'b0;
    blink_mask = 4'b0011;
    do_reset();
    run_to(2);   check("blink_f0_d0", 4'b1110, 4'h4, 1'b1, 1'b0);
    run_to(34);  check("blink_f1_d0", 4'b1110, 4'h4, 1'b1, 1'b0);
    run_to(42);  check("blink_f1_d1", 4'b1101, 4'h3, 1'b1, 1'b0);
    run_to(66);  check("blink_f2_d0", 4'b1111, 4'h4, 1'b1, 1'b0);
    run_to(74);  check("blink_f2_d1", 4'b1111, 4'h3, 1'b1, 1'b0);
    run_to(90);  check("blink_f2_d3", 4'b0111, 4'h1, 1'b1, 1'b0);
    run_to(98);  check("blink_f3_d0", 4'b1111, 4'h4, 1'b1, 1'b0);
    run_to(130); check("blink_f4_d0", 4'b1110, 4'h4, 1'b1, 1'b0);

    // Reset in SHOW of slot 2 while blink is in its off phase
    run_to(210); check("pre_rst_f6_d2", 4'b1011, 4'h2, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst", 4'b1111, 4'h0, 1'b1, 1'b0);
    rst = 1'b0;
    cur = -1;
    run_to(0); check("post_rst_guard", 4'b1111, 4'h4, 1'b1, 1'b1);
    run_to(2); check("post_rst_blink_on", 4'b1110, 4'h4, 1'b1, 1'b0);

    // Tear-free latching
    blink_mask = 4'b0000;
    do_reset();
    run_to(18); check("tear_d2", 4'b1011, 4'h2, 1'b1, 1'b0);
    digits = 16'h5678;
    run_to(26); check("tear_d3_old", 4'b0111, 4'h1, 1'b1, 1'b0);
    run_to(31); check("tear_d3_last", 4'b0111, 4'h1, 1'b1, 1'b0);
    run_to(32); check("tear_new_guard", 4'b1111, 4'h8, 1'b1, 1'b1);
    run_to(34); check("tear_new_d0", 4'b1110, 4'h8, 1'b1, 1'b0);
    run_to(42); check("tear_new_d1", 4'b1101, 4'h7, 1'b1, 1'b0);

    // Enable hold with decimal point on digit 2
    digits = 16'h1234;
    dp_mask = 4'b0100;
    do_reset();
    run_to(10); check("en_d1", 4'b1101, 4'h3, 1'b1, 1'b0);
    enable = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      cur++;
      @(negedge clk);
      if (an !== 4'b1111 || strobe !== 1'b0 || dp_n !== 1'b1) bad++;
    end
    check_int("en_off_dark", bad, 0);
    enable = 1'b1;
    run_to(31); check("en_resume_d1", 4'b1101, 4'h3, 1'b1, 1'b0);
    run_to(35); check("en_d1_last", 4'b1101, 4'h3, 1'b1, 1'b0);
    run_to(36); check("en_d2_strobe", 4'b1111, 4'h2, 1'b1, 1'b1);
    run_to(37); check("en_d2_guard", 4'b1111, 4'h2, 1'b1, 1'b0);
    run_to(38); check("dp_d2_show", 4'b1011, 4'h2, 1'b0, 1'b0);
    run_to(43); check("dp_d2_last", 4'b1011, 4'h2, 1'b0, 1'b0);
    run_to(46); check("dp_d3_off", 4'b0111, 4'h1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
